// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, BITS_PER_CYCLE bits per clock, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);
   localparam int K = WIDTH / BITS_PER_CYCLE;
   localparam int CW = K > 1 ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic c_q, c_d, cout_q, cout_d, cy;
   logic [BITS_PER_CYCLE-1:0] slice;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic ovf_q, ovf_d, cmsb;
`endif
   // Ripple of full-adder cells over the low slice; a_q doubles as the result shifter.
   always_comb begin
      cy = c_q;
      slice = '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      cmsb = c_q;
`endif
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef SERIAL_ADD_SUB_OVF_EN
         cmsb = cy;
`endif
         slice[i] = a_q[i] ^ b_q[i] ^ cy;
         cy = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
      end
   end
   always_comb begin
      state_d = state_q == RUN ? (cnt_q == LAST ? DONE : RUN) : (start ? RUN : IDLE);
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      cnt_d = cnt_q;
      sum_d = sum_q;
      cout_d = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_d = ovf_q;
`endif
      if (state_q == RUN) begin
         a_d = WIDTH'({slice, a_q} >> BITS_PER_CYCLE);
         b_d = b_q >> BITS_PER_CYCLE;
         c_d = cy;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            sum_d = a_d;
            cout_d = cy;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_d = cmsb ^ cy;
`endif
         end
      end else if (start) begin
         a_d = a;
         b_d = b ^ {WIDTH{sub}};
         c_d = sub;
         cnt_d = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         c_q <= 1'b0;
         cnt_q <= '0;
         sum_q <= '0;
         cout_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         cnt_q <= cnt_d;
         sum_q <= sum_d;
         cout_q <= cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
   assign sum = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
   assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of serial_add_sub at 1 and 4 bits per cycle.
module tb_serial_add_sub;
   logic clk, rst, start, sub, busy, done, cout;
   logic [7:0] a, b, sum;
   logic start4, sub4, busy4, done4, cout4;
   logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic ovf, ovf4;
`endif
   int checks = 0, errors = 0;
   logic [7:0] last_sum;
   serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADD_SUB_OVF_EN
      .ovf(ovf),
`endif
      .cout(cout));
   serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADD_SUB_OVF_EN
      .ovf(ovf4),
`endif
      .cout(cout4));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo);
      a = ta; b = tb_; sub = ts; start = 1'b1;
      tick;
      start = 1'b0; a = ~ta; b = ~tb_; sub = ~ts;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done0"}, 32'(done), 32'd0);
      repeat (3) tick;
      chk({tag, " hold_mid"}, 32'(sum), 32'(last_sum));
      repeat (4) tick;
      chk({tag, " busy_last"}, 32'(busy), 32'd1);
      tick;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy_off"}, 32'(busy), 32'd0);
      chk({tag, " sum"}, 32'(sum), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_SUB_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`endif
      tick;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " hold_after"}, 32'(sum), 32'(es));
      last_sum = es;
   endtask
   initial begin
      rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
      start4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
      last_sum = 8'h00;
      tick; tick;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      chk("reset busy4", 32'(busy4), 32'd0);
      rst = 1'b0; start = 1'b0;
      tick;
      chk("idle busy", 32'(busy), 32'd0);
      run_op("add", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      run_op("sub_noborrow", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
      // Operands churn while start stays high; only the accepted ones count.
      a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
      tick;
      chk("hs busy", 32'(busy), 32'd1);
      for (int i = 0; i < 7; i++) begin
         a = a + 8'h11; b = ~b; sub = ~sub;
         tick;
      end
      chk("hs busy_last", 32'(busy), 32'd1);
      a = 8'h77;
      tick;
      chk("hs done", 32'(done), 32'd1);
      chk("hs sum", 32'(sum), 32'h03);
      chk("hs cout", 32'(cout), 32'd0);
      a = 8'h0A; b = 8'h05; sub = 1'b1;
      tick;
      chk("b2b busy", 32'(busy), 32'd1);
      chk("b2b done", 32'(done), 32'd0);
      start = 1'b0;
      repeat (7) tick;
      tick;
      chk("b2b done2", 32'(done), 32'd1);
      chk("b2b sum", 32'(sum), 32'h05);
      chk("b2b cout", 32'(cout), 32'd1);
      tick;
      // Abort on the third RUN cycle.
      a = 8'h55; b = 8'h11; sub = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort sum", 32'(sum), 32'd0);
      chk("abort cout", 32'(cout), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("abort no_done", 32'(done), 32'd0);
      end
      last_sum = 8'h00;
      run_op("fresh", 8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);
      a4 = 8'hA5; b4 = 8'h5B; sub4 = 1'b0; start4 = 1'b1;
      tick;
      start4 = 1'b0;
      chk("b4 busy", 32'(busy4), 32'd1);
      tick;
      chk("b4 busy2", 32'(busy4), 32'd1);
      chk("b4 done_early", 32'(done4), 32'd0);
      tick;
      chk("b4 done", 32'(done4), 32'd1);
      chk("b4 sum", 32'(sum4), 32'h00);
      chk("b4 cout", 32'(cout4), 32'd1);
`ifdef SERIAL_ADD_SUB_OVF_EN
      chk("b4 ovf", 32'(ovf4), 32'd0);
`endif
      a4 = 8'h30; b4 = 8'h50; sub4 = 1'b1; start4 = 1'b1;
      tick;
      start4 = 1'b0;
      tick; tick;
      chk("b4 sub done", 32'(done4), 32'd1);
      chk("b4 sub sum", 32'(sum4), 32'hE0);
      chk("b4 sub cout", 32'(cout4), 32'd0);
      tick;
      chk("b4 idle", 32'(done4), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, the operand bits processed per clock; it SHALL divide WIDTH exactly.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation using the current a, b and sub.
REQ-006 SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: the operands, sampled only on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-010 SHALL have port sum, output, WIDTH bits: the registered result.
REQ-011 SHALL have port cout, output, 1 bit: the registered carry out of the MSB.

Function
REQ-012 SHALL implement a three-state machine IDLE, RUN, DONE; reset state is IDLE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: latch a, latch b XOR {WIDTH{sub}}, set carry to sub, clear the slice counter, and go to RUN.
REQ-014 In RUN, start SHALL be ignored, and a, b and sub changes SHALL have no effect.
REQ-015 In RUN, each edge SHALL add one BITS_PER_CYCLE slice LSB-first with a ripple of full-adder cells and register the slice carry for the next slice.
REQ-016 After K = WIDTH/BITS_PER_CYCLE RUN edges, the machine SHALL go to DONE; done SHALL be visible K cycles after the accepting edge.
REQ-017 On that final edge, sum SHALL load the full WIDTH-bit result and cout SHALL load the final carry.
REQ-018 sum and cout SHALL hold their previous values at every other time; partial results SHALL NOT appear on sum.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE, which lasts one cycle.
REQ-020 DONE SHALL go to IDLE without start, or directly to RUN with start; this allows back-to-back operations with one DONE cycle between them.
REQ-021 The result SHALL equal (a + (sub ? ~b : b) + sub) mod 2^WIDTH.
REQ-022 For subtraction, cout=1 SHALL mean no borrow (a >= b unsigned), and cout=0 SHALL mean borrow.

Reset
REQ-023 While rst=1, the machine SHALL enter IDLE and clear sum, cout, busy, done and all internal registers; rst SHALL take priority over start.
REQ-024 A reset during RUN SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Configuration
REQ-025 With macro SERIAL_ADD_SUB_OVF_EN defined, an output port ovf, 1 bit, SHALL exist: registered two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB. It SHALL update with sum, hold otherwise, and reset to 0.
REQ-026 Without SERIAL_ADD_SUB_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, BITS_PER_CYCLE=1 unless stated)
REQ-027 Basic add: a=0x35, b=0x4A, sub=0, start for one cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle, sum=0x7F, cout=0, ovf=0.
REQ-028 Add wrap: a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0; separately a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1 (macro defined).
REQ-029 Subtract: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow); a=0x20, b=0x10 -> sum=0x10, cout=1.
REQ-030 Handshake: start held high throughout RUN with changing operands -> only the first operands are used; start high during DONE -> a new RUN begins on the next edge, with no IDLE cycle.
REQ-031 Reset mid-operation: rst=1 on the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse follows; a fresh start then completes correctly.
REQ-032 BITS_PER_CYCLE=4: a=0xA5, b=0x5B, sub=0 -> done 2 cycles after acceptance, sum=0x00, cout=1.
